// File: rtl/frame_stream_tx.sv
// Raster-stream transmitter: walks frame positions, reads active pixels from a synchronous
// frame buffer and emits vsync/hsync/de/data with the read data aligned to de.
//
// state    | meaning
// ST_IDLE  | waiting for i_start; issues position (0,0) on the accepting edge
// ST_RUN   | issuing one raster position per cycle
// ST_DRAIN | last position issued, waiting for it to leave the output stage
module frame_stream_tx #(
    parameter int WIDTH   = 8,
    parameter int H_RES   = 80,
    parameter int V_RES   = 60,
    parameter int H_BLANK = 20,
    parameter int HS_W    = 4,
    parameter int V_PRE   = 2,
    parameter int V_POST  = 2,
    parameter int ADDR_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_continuous,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [WIDTH-1:0]  i_mem_data,
    output logic              o_vsync,
    output logic              o_hsync,
    output logic              o_de,
    output logic [WIDTH-1:0]  o_data
);

    localparam int H_TOT = H_RES + H_BLANK;
    localparam int V_TOT = V_PRE + V_RES + V_POST;
    localparam int H_W   = $clog2(H_TOT);
    localparam int V_W   = $clog2(V_TOT);

    localparam logic [H_W-1:0] H_LAST      = H_W'(H_TOT - 1);
    localparam logic [V_W-1:0] V_LAST      = V_W'(V_TOT - 1);
    localparam logic [31:0]    H_RES_U     = H_RES;
    localparam logic [31:0]    HS_END_U    = H_RES + HS_W;
    localparam logic [31:0]    V_PRE_U     = V_PRE;
    localparam logic [31:0]    V_ACT_END_U = V_PRE + V_RES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    // h/v always hold the next position to be issued
    logic [H_W-1:0] h, h_nxt, ih;
    logic [V_W-1:0] v, v_nxt, iv;
    logic           issue;
    logic           run_last;

    logic iss_active, iss_vsync, iss_hsync, iss_last, iss_first;

    logic [ADDR_W-1:0] rd_addr;
    logic              vs1, hs1, last1;
    logic              vs2, hs2, de2, last2;

    assign run_last = (h == H_LAST) && (v == V_LAST);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        ih        = h;
        iv        = v;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    issue     = 1'b1;
                    ih        = '0;
                    iv        = '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                issue = 1'b1;
                if (run_last && !i_continuous) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (o_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        h_nxt = h;
        v_nxt = v;
        if (issue) begin
            if (ih == H_LAST) begin
                h_nxt = '0;
                v_nxt = (iv == V_LAST) ? '0 : iv + V_W'(1);
            end else begin
                h_nxt = ih + H_W'(1);
            end
        end
    end

    assign iss_active = (32'(iv) >= V_PRE_U) && (32'(iv) < V_ACT_END_U) && (32'(ih) < H_RES_U);
    assign iss_vsync  = 32'(iv) < V_PRE_U;
    assign iss_hsync  = (32'(ih) >= H_RES_U) && (32'(ih) < HS_END_U);
    assign iss_last   = (ih == H_LAST) && (iv == V_LAST);
    assign iss_first  = (ih == '0) && (iv == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            h     <= '0;
            v     <= '0;
        end else begin
            state <= state_nxt;
            h     <= h_nxt;
            v     <= v_nxt;
        end
    end

    // Read slot; the address counter restarts at every frame's (0,0), which is never active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr    <= '0;
            o_mem_rd   <= 1'b0;
            o_mem_addr <= '0;
            vs1        <= 1'b0;
            hs1        <= 1'b0;
            last1      <= 1'b0;
        end else begin
            o_mem_rd <= issue && iss_active;
            vs1      <= issue && iss_vsync;
            hs1      <= issue && iss_hsync;
            last1    <= issue && iss_last;
            if (issue && iss_first) begin
                rd_addr <= '0;
            end
            if (issue && iss_active) begin
                o_mem_addr <= rd_addr;
                rd_addr    <= rd_addr + ADDR_W'(1);
            end
        end
    end

    // Stage 2 lines up with the cycle the frame buffer presents i_mem_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs2   <= 1'b0;
            hs2   <= 1'b0;
            de2   <= 1'b0;
            last2 <= 1'b0;
        end else begin
            vs2   <= vs1;
            hs2   <= hs1;
            de2   <= o_mem_rd;
            last2 <= last1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vsync <= 1'b0;
            o_hsync <= 1'b0;
            o_de    <= 1'b0;
            o_data  <= '0;
            o_done  <= 1'b0;
        end else begin
            o_vsync <= vs2;
            o_hsync <= hs2;
            o_de    <= de2;
            o_data  <= de2 ? i_mem_data : '0;
            o_done  <= last2;
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_frame_stream_tx.sv
// Directed bench for frame_stream_tx on a 4x3 frame (H_TOT=6, V_TOT=5): compares every
// cycle against a position-based raster model and checks hand-computed event cycles.
module tb_frame_stream_tx;

    localparam int WIDTH   = 8;
    localparam int H_RES   = 4;
    localparam int V_RES   = 3;
    localparam int H_BLANK = 2;
    localparam int HS_W    = 1;
    localparam int V_PRE   = 1;
    localparam int V_POST  = 1;
    localparam int ADDR_W  = 13;
    localparam int H_TOT   = 6;
    localparam int NPOS    = 30;
    localparam int NPIX    = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic              i_continuous = 1'b0;
    logic              o_busy, o_done, o_mem_rd;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [WIDTH-1:0]  i_mem_data;
    logic              o_vsync, o_hsync, o_de;
    logic [WIDTH-1:0]  o_data;

    logic [7:0]  mem [0:NPIX-1];
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    int          bases[$];
    int          done_q[$];
    logic [12:0] exp_addr = '0;
    int          de_cnt = 0;
    int          first_de = -1;
    int          c0;

    frame_stream_tx #(
        .WIDTH(WIDTH), .H_RES(H_RES), .V_RES(V_RES), .H_BLANK(H_BLANK), .HS_W(HS_W),
        .V_PRE(V_PRE), .V_POST(V_POST), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_continuous(i_continuous),
        .o_busy(o_busy), .o_done(o_done), .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr),
        .i_mem_data(i_mem_data), .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
        .o_data(o_data)
    );

    always #5 clk = ~clk;

    // Synchronous frame buffer: data valid the cycle after the read; junk otherwise
    always @(posedge clk) begin
        if (o_mem_rd && (o_mem_addr < 13'(NPIX))) i_mem_data <= mem[o_mem_addr];
        else                                      i_mem_data <= 8'hA5;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    function automatic bit act(input int p);
        int hh, vv;
        hh = p % H_TOT;
        vv = p / H_TOT;
        return (vv >= V_PRE) && (vv < V_PRE + V_RES) && (hh < H_RES);
    endfunction

    function automatic int pix(input int p);
        return (p / H_TOT - V_PRE) * H_RES + p % H_TOT;
    endfunction

    task automatic model(input int c, output bit busy, output bit rd, output bit vs,
                         output bit hs, output bit de, output bit done,
                         output int ra, output int data);
        busy = 0; rd = 0; vs = 0; hs = 0; de = 0; done = 0; ra = 0; data = 0;
        foreach (bases[i]) begin
            int b;
            int p;
            b = bases[i];
            if (c >= b + 1 && c <= b + NPOS + 2) busy = 1;
            p = c - b - 1;
            if (p >= 0 && p < NPOS && act(p)) begin
                rd = 1;
                ra = pix(p);
            end
            p = c - b - 3;
            if (p >= 0 && p < NPOS) begin
                vs   = (p / H_TOT) < V_PRE;
                hs   = (p % H_TOT) >= H_RES && (p % H_TOT) < H_RES + HS_W;
                de   = act(p);
                done = (p == NPOS - 1);
                if (de) data = int'(mem[pix(p)]);
            end
        end
    endtask

    task automatic tick_chk();
        bit e_busy, e_rd, e_vs, e_hs, e_de, e_done;
        int e_ra, e_data;
        @(posedge clk);
        #1;
        cyc++;
        model(cyc, e_busy, e_rd, e_vs, e_hs, e_de, e_done, e_ra, e_data);
        if (e_rd) exp_addr = e_ra[12:0];
        chk("busy",     32'(o_busy),     32'(e_busy));
        chk("mem_rd",   32'(o_mem_rd),   32'(e_rd));
        chk("mem_addr", 32'(o_mem_addr), 32'(exp_addr));
        chk("vsync",    32'(o_vsync),    32'(e_vs));
        chk("hsync",    32'(o_hsync),    32'(e_hs));
        chk("de",       32'(o_de),       32'(e_de));
        chk("data",     32'(o_data),     e_data);
        chk("done",     32'(o_done),     32'(e_done));
        if (o_de === 1'b1) begin
            de_cnt++;
            if (first_de < 0) first_de = cyc;
        end
        if (o_done === 1'b1) done_q.push_back(cyc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(o_busy),     0);
        chk({tag, "_done"},  32'(o_done),     0);
        chk({tag, "_rd"},    32'(o_mem_rd),   0);
        chk({tag, "_addr"},  32'(o_mem_addr), 0);
        chk({tag, "_vsync"}, 32'(o_vsync),    0);
        chk({tag, "_hsync"}, 32'(o_hsync),    0);
        chk({tag, "_de"},    32'(o_de),       0);
        chk({tag, "_data"},  32'(o_data),     0);
    endtask

    task automatic clear_stats();
        bases.delete();
        done_q.delete();
        de_cnt   = 0;
        first_de = -1;
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i + 16);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) tick_chk();

        // Single frame: sync shape, data 16..27, done at +32, busy +1..+32
        clear_stats();
        c0 = cyc;
        bases.push_back(c0);
        i_start = 1'b1;
        tick_chk();
        i_start = 1'b0;
        repeat (35) tick_chk();
        chk("single_de_count", de_cnt, 12);
        chk("single_first_de", first_de - c0, 9);
        chk("single_done_count", done_q.size(), 1);
        if (done_q.size() > 0) chk("single_done_cycle", done_q[0] - c0, 32);

        // Continuous: second frame right behind, then drop i_continuous mid second frame
        clear_stats();
        c0 = cyc;
        bases.push_back(c0);
        bases.push_back(c0 + NPOS);
        i_start = 1'b1;
        i_continuous = 1'b1;
        tick_chk();
        i_start = 1'b0;
        repeat (38) tick_chk();
        i_continuous = 1'b0;
        repeat (30) tick_chk();
        chk("cont_de_count", de_cnt, 24);
        chk("cont_done_count", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("cont_done0", done_q[0] - c0, 32);
            chk("cont_done1", done_q[1] - c0, 62);
        end

        // i_start held high: no mid-frame restart, next frame 3 cycles after first IDLE cycle
        clear_stats();
        c0 = cyc;
        bases.push_back(c0);
        bases.push_back(c0 + 33);
        i_start = 1'b1;
        repeat (34) tick_chk();
        i_start = 1'b0;
        repeat (34) tick_chk();
        chk("hold_done_count", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("hold_done0", done_q[0] - c0, 32);
            chk("hold_done1", done_q[1] - c0, 65);
        end

        // Reset mid-frame at relative cycle 15 (an active pixel is on the outputs)
        clear_stats();
        c0 = cyc;
        bases.push_back(c0);
        i_start = 1'b1;
        tick_chk();
        i_start = 1'b0;
        repeat (14) tick_chk();
        chk("pre_reset_de", 32'(o_de), 1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk);
        #1;
        cyc++;
        chk_all_zero("midrst_hold");
        rst = 1'b0;
        clear_stats();
        exp_addr = '0;
        repeat (4) tick_chk();
        chk("midrst_no_done", done_q.size(), 0);

        // Clean frame after reset with random pixel values: alignment of data to read address
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 255));
        clear_stats();
        c0 = cyc;
        bases.push_back(c0);
        i_start = 1'b1;
        tick_chk();
        i_start = 1'b0;
        repeat (35) tick_chk();
        chk("rand_de_count", de_cnt, 12);
        chk("rand_done_count", done_q.size(), 1);
        if (done_q.size() > 0) chk("rand_done_cycle", done_q[0] - c0, 32);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/frame_stream_tx.md
Name: frame_stream_tx

Overview:
- Video-stream transmitter that feeds the edge-detection path.
- Reads a grayscale frame from a synchronous frame-buffer read port and emits it as a raster stream on o_vsync/o_hsync/o_de/o_data, with programmable horizontal and vertical blanking.
- Provides the blanking the downstream line-buffered filters need between lines, plus post-frame lines to drain their pipelines.
- Single-shot or continuous operation, under i_start/o_busy/o_done control.

Parameters:
- WIDTH, 8, pixel bit width.
- H_RES, 80, active pixels per line.
- V_RES, 60, active lines per frame.
- H_BLANK, 20, blank cycles after each line (≥ HS_W, ≥ 1).
- HS_W, 4, hsync pulse width in cycles, at start of each H blank.
- V_PRE, 2, blank lines before active region (vsync high); must be ≥ 1.
- V_POST, 2, blank lines after active region (pipeline flush).
- ADDR_W, 13, frame-buffer address width; must hold H_RES*V_RES-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_start  in  1  start-frame request, sampled only in IDLE
- i_continuous  in  1  when high at the last frame position, restart immediately
- o_busy  out  1  transmitting
- o_done  out  1  one-cycle end-of-frame pulse
- o_mem_rd  out  1  frame-buffer read enable
- o_mem_addr  out  ADDR_W  frame-buffer read address
- i_mem_data  in  WIDTH  read data, valid exactly 1 cycle after o_mem_rd
- o_vsync  out  1  vertical sync
- o_hsync  out  1  horizontal sync
- o_de  out  1  active-pixel data enable
- o_data  out  WIDTH  pixel data

Interface (already decided): one clock; reset is asynchronous and active-high (clk, rst).

Behaviour:
- Reset:
  - All outputs are 0 immediately on rst assertion: busy, done, mem_rd, mem_addr, vsync, hsync, de, data.
  - State goes to IDLE; counters clear.
  - Reset mid-frame abandons the frame. No partial o_done is produced.
- Geometry: H_TOT = H_RES + H_BLANK; V_TOT = V_PRE + V_RES + V_POST. A frame is V_TOT*H_TOT positions (h, v), raster order.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on i_start = 1. Counters h = 0, v = 0.
  - RUN advances one position per cycle. h wraps at H_TOT-1, incrementing v.
  - At the last position (h = H_TOT-1, v = V_TOT-1):
    - If i_continuous = 1, wrap to (0, 0) and stay in RUN.
    - Otherwise go to DRAIN.
  - DRAIN waits for the output pipeline to empty, then goes to IDLE.
  - i_start is ignored outside IDLE.
- Per-position timing:
  - active = (V_PRE ≤ v < V_PRE+V_RES) and (h < H_RES).
  - vsync = (v < V_PRE).
  - hsync = (H_RES ≤ h < H_RES+HS_W), on every line including blank lines.
- Memory read:
  - o_mem_rd (registered) is high one cycle per active position.
  - o_mem_addr comes from an incrementing counter (no multiplier). It is reset to 0 at each frame start and increments after each read, covering 0..H_RES*V_RES-1 in order.
  - o_mem_addr holds its last value while o_mem_rd = 0.
- Output alignment:
  - vsync/hsync/de for a position appear on the outputs exactly 2 cycles after that position's o_mem_rd slot, so o_data = i_mem_data is aligned with o_de.
  - o_data = 0 whenever o_de = 0.
- Latency: position (0, 0) is on the outputs 3 cycles after the i_start sampling edge. After that, positions are presented on consecutive cycles with no gaps, including across frames in continuous mode.
- o_done:
  - One-cycle pulse concurrent with the output cycle of each frame's last position.
  - Pulses in continuous mode as well.
- o_busy:
  - High from the cycle after the i_start edge until and including the o_done cycle of the final frame.
  - Low in the following cycle.
  - A new i_start is accepted in the cycle o_busy is low.
- i_continuous may toggle at any time; only its value at the last position matters.

Test Plan:
Common configuration for all scenarios: H_RES=4, V_RES=3, H_BLANK=2, HS_W=1, V_PRE=1, V_POST=1 (H_TOT=6, V_TOT=5, 30 positions). i_mem_data = address+16.
1. Single frame: i_start pulse at edge 0 -> outputs occupy cycles 3..32. o_de high exactly 12 cycles with o_data 16..27 in order. o_mem_addr 0..11. o_done only in cycle 32. o_busy high in cycles 1..32.
2. Sync shape: same run -> o_vsync high cycles 3..8. o_hsync high in output cycles 7, 13, 19, 25, 31. No o_de during vsync or the post line. o_data 0 whenever o_de is low.
3. Continuous: i_continuous=1 -> second frame's (0,0) on cycle 33, o_addr restarts at 0. o_done in cycles 32 and 62. Drop i_continuous -> busy falls the cycle after the next o_done.
4. Start ignored: i_start held high throughout a single frame -> no restart mid-frame. A new frame begins 3 cycles after the first IDLE cycle.
5. Reset mid-frame: assert rst at cycle 15 -> all outputs 0 in the same cycle, no o_done. After release, an i_start pulse -> clean frame with addresses from 0.
6. Read/data alignment: randomize i_mem_data per address -> each o_de cycle carries the data for the address read exactly 2 cycles earlier.
